// File: rtl/lu_pkg.sv
// lu_pkg: shared definitions for the logic-unit result path.
//   LU_DATA_W / LU_FLAG_W : result word and flag vector widths.
//   LU_FLAG_* : bit positions inside the flag vector {za, zb, eq, gt, lt}.
//   lu_result_t : one captured entry, flags in the upper bits.
package lu_pkg;

  localparam int LU_DATA_W = 32;
  localparam int LU_FLAG_W = 5;

  localparam int LU_FLAG_ZA = 4;
  localparam int LU_FLAG_ZB = 3;
  localparam int LU_FLAG_EQ = 2;
  localparam int LU_FLAG_GT = 1;
  localparam int LU_FLAG_LT = 0;

  typedef struct packed {
    logic [LU_FLAG_W-1:0] flags;
    logic [LU_DATA_W-1:0] data;
  } lu_result_t;

endpackage

// File: rtl/lu_fifo_mem.sv
// lu_fifo_mem: DEPTH x W register array for the result FIFO.
//   clk   : write clock
//   we    : write enable, writes wdata at waddr on the rising edge
//   waddr : write address
//   wdata : write word
//   raddr : read address (asynchronous read)
//   rdata : mem[raddr], no latency
// The array is deliberately not reset; the top level masks the read data
// while the FIFO is empty.
module lu_fifo_mem
  import lu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = LU_DATA_W + LU_FLAG_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lu_result_fifo.sv
// lu_result_fifo: capture FIFO between the logic unit and its consumer.
//   clk, rst            : single clock, synchronous active-high reset
//   in_valid/in_ready   : producer handshake, in_data/in_flags sampled on push
//   out_valid/out_ready : consumer handshake, out_data/out_flags show-ahead
//   count               : occupancy 0..DEPTH
//   drop_err            : sticky, set when in_valid arrives while full
//   clr_err             : clears drop_err (and the stats counters)
// Optional macro LU_RESULT_FIFO_STATS_EN adds eq_cnt, gt_cnt, lt_cnt:
// saturating 16-bit counts of pushed entries with that flag set.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready = !full and out_valid = !empty, both from registered
// count, so neither ready depends combinationally on the other side's valid.
module lu_result_fifo
  import lu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = LU_DATA_W,
  parameter int FLAG_W = LU_FLAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [FLAG_W-1:0]        in_flags,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [FLAG_W-1:0]        out_flags,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err,
  input  logic                     clr_err
`ifdef LU_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]              eq_cnt,
  output logic [15:0]              gt_cnt,
  output logic [15:0]              lt_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int W     = DATA_W + FLAG_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drop_err_q, drop_err_d;

  logic             full, empty, push, pop, drop;
  logic [W-1:0]     rd_word;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // Write is blocked at full even if a pop happens the same cycle.
  assign push  = in_valid & ~full;
  assign pop   = out_ready & ~empty;
  assign drop  = in_valid & full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    // A new drop wins over a concurrent clear.
    if (drop)         drop_err_d = 1'b1;
    else if (clr_err) drop_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  lu_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({in_flags, in_data}),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  // Mask the unreset array so the outputs read zero while empty.
  assign out_data  = empty ? '0 : rd_word[DATA_W-1:0];
  assign out_flags = empty ? '0 : rd_word[W-1:DATA_W];
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = count_q;
  assign drop_err  = drop_err_q;

`ifdef LU_RESULT_FIFO_STATS_EN
  logic [15:0] eq_cnt_q, eq_cnt_d;
  logic [15:0] gt_cnt_q, gt_cnt_d;
  logic [15:0] lt_cnt_q, lt_cnt_d;

  // clr_err takes precedence, so a push in the clearing cycle is not counted.
  always_comb begin
    eq_cnt_d = eq_cnt_q;
    gt_cnt_d = gt_cnt_q;
    lt_cnt_d = lt_cnt_q;
    if (clr_err) begin
      eq_cnt_d = '0;
      gt_cnt_d = '0;
      lt_cnt_d = '0;
    end else if (push) begin
      if (in_flags[LU_FLAG_EQ] && eq_cnt_q != 16'hFFFF) eq_cnt_d = eq_cnt_q + 16'd1;
      if (in_flags[LU_FLAG_GT] && gt_cnt_q != 16'hFFFF) gt_cnt_d = gt_cnt_q + 16'd1;
      if (in_flags[LU_FLAG_LT] && lt_cnt_q != 16'hFFFF) lt_cnt_d = lt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eq_cnt_q <= '0;
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
    end else begin
      eq_cnt_q <= eq_cnt_d;
      gt_cnt_q <= gt_cnt_d;
      lt_cnt_q <= lt_cnt_d;
    end
  end

  assign eq_cnt = eq_cnt_q;
  assign gt_cnt = gt_cnt_q;
  assign lt_cnt = lt_cnt_q;
`endif

endmodule
